gcd_operand_feeder: RTL and testbench

Upstream stage for the subtraction-based GCD datapath/controller pair. Accepts (A,B) operand pairs over a valid/ready handshake and buffers them in a small FIFO. Sequences each pair onto the GCD shared data_in bus: A in the first load cycle, B in the second. Holds the bus, waits for the controller's done, then retires the job and issues the next one.

---
 rtl/gcd_operand_feeder.sv | 173 +++++++++++++++++
 tb/tb_gcd_operand_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_feeder.sv
// Operand-pair FIFO and load sequencer for the subtraction GCD controller.
// Optional `GCD_TIMEOUT_EN adds a RUN watchdog and a timeout output port.
module gcd_operand_feeder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         data_in,
    output logic                     start,
    input  logic                     done,
    output logic                     busy,
    output logic [3:0]               job_tag,
    output logic                     err_zero,
`ifdef GCD_TIMEOUT_EN
    output logic                     timeout,
`endif
    output logic [$clog2(DEPTH):0]   pend_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RUN,
        S_DONE_POP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_memA [DEPTH];
    logic [WIDTH-1:0] r_memB [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_start;
    logic             r_busy;
    logic [3:0]       r_jobTag;
    logic             r_errZero;
    logic             r_runFirst;

    logic w_full;
    logic w_accept;
    logic w_zero;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_accept = in_valid && !w_full;
    assign w_zero   = (in_a == '0) || (in_b == '0);
    assign w_push   = w_accept && !w_zero;
    assign w_pop    = (r_state == S_DONE_POP);

    assign in_ready   = !w_full;
    assign data_in    = r_data;
    assign start      = r_start;
    assign busy       = r_busy;
    assign job_tag    = r_jobTag;
    assign err_zero   = r_errZero;
    assign pend_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memA[r_wrPtr] <= in_a;
            r_memB[r_wrPtr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_errZero <= 1'b0;
        end else begin
            r_errZero <= w_accept && w_zero;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GCD_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] r_runCnt;
    logic           r_timeout;
    assign timeout = r_timeout;
`endif

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rdPtr    <= '0;
            r_data     <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_jobTag   <= '0;
            r_runFirst <= 1'b0;
`ifdef GCD_TIMEOUT_EN
            r_runCnt   <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_busy  <= (r_state != S_IDLE);
            r_start <= 1'b0;
`ifdef GCD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_data <= '0;
                    if (r_count != '0) begin
                        r_state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    r_data  <= r_memA[r_rdPtr];
                    r_start <= 1'b1;
                    r_state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_data     <= r_memB[r_rdPtr];
                    r_runFirst <= 1'b1;
                    r_state    <= S_RUN;
`ifdef GCD_TIMEOUT_EN
                    r_runCnt   <= '0;
`endif
                end
                S_RUN: begin
                    // The first RUN cycle may still see the previous job's done level.
                    r_data     <= r_memB[r_rdPtr];
                    r_runFirst <= 1'b0;
`ifdef GCD_TIMEOUT_EN
                    r_runCnt   <= r_runCnt + 1'b1;
                    if (!r_runFirst && done) begin
                        r_state <= S_DONE_POP;
                    end else if (r_runCnt == TCW'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE_POP;
                    end
`else
                    if (!r_runFirst && done) begin
                        r_state <= S_DONE_POP;
                    end
`endif
                end
                S_DONE_POP: begin
                    r_data   <= '0;
                    r_jobTag <= r_jobTag + 1'b1;
                    r_rdPtr  <= r_rdPtr + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Self-checking bench for gcd_operand_feeder: cycle-offset job model plus directed vectors.
// Exercises the timeout path only when GCD_TIMEOUT_EN is defined.
module tb_gcd_operand_feeder;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 4;
    localparam int TB_TIMEOUT = 16;
`ifdef GCD_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic             done = 1'b0;
    logic             busy;
    logic [3:0]       job_tag;
    logic             err_zero;
    logic             timeout;
    logic [$clog2(DEPTH):0] pend_count;

    int checks = 0;
    int failures = 0;

`ifndef GCD_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    gcd_operand_feeder #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .data_in(data_in),
        .start(start),
        .done(done),
        .busy(busy),
        .job_tag(job_tag),
        .err_zero(err_zero),
`ifdef GCD_TIMEOUT_EN
        .timeout(timeout),
`endif
        .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Model: a queue of accepted pairs and a per-job timeline counted in edges since pickup.
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t            q[$];
    bit               jobActive = 1'b0;
    int               m = 0;
    int               d = -1;
    int               preSize;
    bit               acc;
    bit               zer;
    logic [WIDTH-1:0] eData = '0;
    logic             eStart = 1'b0;
    logic             eBusy = 1'b0;
    logic [3:0]       eTag = '0;
    logic             eErr = 1'b0;
    logic             eTo = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            jobActive = 1'b0;
            m = 0;
            d = -1;
            eData = '0;
            eStart = 1'b0;
            eBusy = 1'b0;
            eTag = '0;
            eErr = 1'b0;
            eTo = 1'b0;
        end else begin
            preSize = q.size();
            acc = in_valid && (preSize < DEPTH);
            zer = acc && ((in_a == '0) || (in_b == '0));
            eTo = 1'b0;
            if (!jobActive) begin
                eData  = '0;
                eStart = 1'b0;
                eBusy  = 1'b0;
                if (preSize > 0) begin
                    jobActive = 1'b1;
                    m = 0;
                    d = -1;
                end
            end else begin
                m++;
                eStart = (m == 1);
                eBusy  = 1'b1;
                if (d < 0 && m >= 4 && done) begin
                    d = m;
                end else if (d < 0 && TO_ON && m == 2 + TB_TIMEOUT) begin
                    d = m;
                    eTo = 1'b1;
                end
                if (m == 1) begin
                    eData = q[0].a;
                end else if (d >= 0 && m == d + 1) begin
                    eData = '0;
                    eTag = eTag + 4'd1;
                    void'(q.pop_front());
                    jobActive = 1'b0;
                end else begin
                    eData = q[0].b;
                end
            end
            if (acc && !zer) begin
                q.push_back('{a: in_a, b: in_b});
            end
            eErr = zer;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("data_in", 32'(data_in), 32'(eData));
            checkOutput("start", 32'(start), 32'(eStart));
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("job_tag", 32'(job_tag), 32'(eTag));
            checkOutput("err_zero", 32'(err_zero), 32'(eErr));
            checkOutput("pend_count", 32'(pend_count), 32'(q.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            checkOutput("timeout", 32'(timeout), 32'(eTo));
        end
    end

    task waitStart(input string name, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = (start === 1'b1);
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    task waitIdle(input string name, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = (busy === 1'b0) && (pend_count == '0);
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=hung expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_data_in", 32'(data_in), 32'd0);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_job_tag", 32'(job_tag), 32'd0);
        checkOutput("rst_pend", 32'(pend_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_err_zero", 32'(err_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job: LOAD_A outputs two edges after the accepting edge.
        applyStimulus(1'b1, 16'd48, 16'd18);
        @(negedge clk);
        checkOutput("t1_pre_start", 32'(start), 32'd0);
        @(negedge clk);
        checkOutput("t1_start", 32'(start), 32'd1);
        checkOutput("t1_data_a", 32'(data_in), 32'd48);
        @(negedge clk);
        checkOutput("t1_data_b", 32'(data_in), 32'd18);
        checkOutput("t1_start_low", 32'(start), 32'd0);
        repeat (10) @(negedge clk);
        done = 1'b1;
        waitIdle("t1_idle_wait", 20);
        checkOutput("t1_job_tag", 32'(job_tag), 32'd1);
        checkOutput("t1_pend", 32'(pend_count), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // Fill the FIFO, then a refused fifth pair.
        applyStimulus(1'b1, 16'd10, 16'd4);
        applyStimulus(1'b1, 16'd15, 16'd5);
        applyStimulus(1'b1, 16'd9, 16'd3);
        applyStimulus(1'b1, 16'd8, 16'd2);
        checkOutput("t2_full_pend", 32'(pend_count), 32'd4);
        checkOutput("t2_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 16'd7, 16'd7);
        checkOutput("t2_refused_pend", 32'(pend_count), 32'd4);
        repeat (3) @(negedge clk);
        done = 1'b1;
        begin
            bit moved;
            moved = 1'b0;
            for (int i = 0; i < 10 && !moved; i++) begin
                @(negedge clk);
                moved = (pend_count != 3'd4);
            end
            checkOutput("t2_pop_wait", 32'(moved), 32'd1);
        end
        checkOutput("t2_pop_pend", 32'(pend_count), 32'd3);
        checkOutput("t2_pop_ready", 32'(in_ready), 32'd1);
        waitIdle("t2_drain_wait", 100);
        checkOutput("t2_job_tag", 32'(job_tag), 32'd5);
        done = 1'b0;
        @(negedge clk);

        // Zero operands are rejected with an error pulse.
        applyStimulus(1'b1, 16'd0, 16'd5);
        checkOutput("t3_err1", 32'(err_zero), 32'd1);
        checkOutput("t3_pend1", 32'(pend_count), 32'd0);
        applyStimulus(1'b1, 16'd7, 16'd0);
        checkOutput("t3_err2", 32'(err_zero), 32'd1);
        checkOutput("t3_pend2", 32'(pend_count), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("t3_no_busy", 32'(busy), 32'd0);

        // Two queued jobs in order; done stays high across the second job.
        applyStimulus(1'b1, 16'd12, 16'd8);
        applyStimulus(1'b1, 16'd9, 16'd6);
        waitStart("t4_start1_wait", 10);
        checkOutput("t4_a1", 32'(data_in), 32'd12);
        @(negedge clk);
        checkOutput("t4_b1", 32'(data_in), 32'd8);
        repeat (4) @(negedge clk);
        done = 1'b1;
        waitStart("t4_start2_wait", 20);
        checkOutput("t4_a2", 32'(data_in), 32'd9);
        @(negedge clk);
        checkOutput("t4_b2", 32'(data_in), 32'd6);
        waitIdle("t4_idle_wait", 20);
        checkOutput("t4_job_tag", 32'(job_tag), 32'd7);
        done = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in RUN.
        applyStimulus(1'b1, 16'd30, 16'd12);
        waitStart("t5_start_wait", 10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_data", 32'(data_in), 32'd0);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        checkOutput("t5_async_tag", 32'(job_tag), 32'd0);
        checkOutput("t5_async_pend", 32'(pend_count), 32'd0);
        checkOutput("t5_async_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 16'd21, 16'd14);
        waitStart("t5_restart_wait", 10);
        checkOutput("t5_a", 32'(data_in), 32'd21);
        @(negedge clk);
        checkOutput("t5_b", 32'(data_in), 32'd14);
        checkOutput("t5_tag_mid", 32'(job_tag), 32'd0);
        repeat (3) @(negedge clk);
        done = 1'b1;
        waitIdle("t5_idle_wait", 20);
        checkOutput("t5_job_tag", 32'(job_tag), 32'd1);
        done = 1'b0;
        @(negedge clk);

`ifdef GCD_TIMEOUT_EN
        // Watchdog: start seen, then timeout 17 edges later with done held low.
        applyStimulus(1'b1, 16'd5, 16'd3);
        waitStart("t6_start_wait", 10);
        begin
            int gap;
            bit seen;
            gap = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                gap++;
                seen = (timeout === 1'b1);
            end
            checkOutput("t6_timeout_wait", 32'(seen), 32'd1);
            checkOutput("t6_timeout_gap", 32'(gap), 32'd17);
        end
        waitIdle("t6_idle_wait", 10);
        checkOutput("t6_job_tag", 32'(job_tag), 32'd2);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
